// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and stall signals of the unified-memory port arbiter
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int INSTRUCTIONWIDTH = 24
);
  logic fetchReq;
  logic [WIDTH-1:0] fetchAddr;
  logic fetchValid;
  logic [INSTRUCTIONWIDTH-1:0] fetchInstr;
  logic dataReq;
  logic dataWe;
  logic [WIDTH-1:0] dataAddr;
  logic [WIDTH-1:0] dataWData;
  logic dataValid;
  logic [WIDTH-1:0] dataRData;
  logic ioReq;
  logic ioWe;
  logic [WIDTH-1:0] ioAddr;
  logic [WIDTH-1:0] ioWData;
  logic ioValid;
  logic [WIDTH-1:0] ioRData;
  logic memEn;
  logic memWe;
  logic [WIDTH-1:0] memAddr;
  logic [WIDTH-1:0] memWData;
  logic [WIDTH-1:0] memRData;
  logic stallFetch;
  logic stallMem;
  logic busy;
  modport slave (
    input  fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWData,
           ioReq, ioWe, ioAddr, ioWData, memRData,
    output fetchValid, fetchInstr, dataValid, dataRData, ioValid, ioRData,
           memEn, memWe, memAddr, memWData, stallFetch, stallMem, busy
  );
  modport master (
    output fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWData,
           ioReq, ioWe, ioAddr, ioWData, memRData,
    input  fetchValid, fetchInstr, dataValid, dataRData, ioValid, ioRData,
           memEn, memWe, memAddr, memWData, stallFetch, stallMem, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port memory between fetch, load/store and IO loader,
// one access per two cycles; ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int STARVELIMIT = 8
) (
  input logic clock,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {ISSUE, RESPOND} stateE;
  typedef enum logic [1:0] {DATA = 2'd0, FETCH = 2'd1, IO = 2'd2} ownerE;
  stateE state, stateNext;
  ownerE owner, grant;
  logic [2:0] reqs;
  logic anyReq, issueNow, respondNow;
  logic fetchDone, dataDone, ioDone;
  logic memEn, memWe;
  logic [WIDTH-1:0] memAddr, memWData;
  logic [INSTRUCTIONWIDTH-1:0] fetchInstrHeld;
  logic [WIDTH-1:0] dataRDataHeld, ioRDataHeld;
  assign reqs = {bus.ioReq, bus.fetchReq, bus.dataReq};
  assign anyReq = |reqs;
  assign issueNow = (state == ISSUE) && anyReq && !reset;
  assign respondNow = (state == RESPOND) && !reset;
`ifdef ARB_ROUND_ROBIN_EN
  ownerE rrPtr;
  logic [2:0] rrSum;
  logic [1:0] rrCand;
  // search from the pointer in order data, fetch, io; the nearest requester wins
  always_comb begin
    grant = DATA;
    rrSum = 3'd0;
    rrCand = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      rrSum = {1'b0, rrPtr} + 3'(i);
      rrCand = (rrSum > 3'd2) ? 2'(rrSum - 3'd3) : rrSum[1:0];
      if (reqs[rrCand]) grant = ownerE'(rrCand);
    end
  end
  // pointer moves to the requester after the one just granted
  always_ff @(posedge clock) begin
    if (reset) rrPtr <= DATA;
    else if (issueNow) rrPtr <= (grant == IO) ? DATA : ownerE'(grant + 2'd1);
  end
`else
  logic [3:0] starveCnt;
  logic starved;
  assign starved = starveCnt >= 4'(STARVELIMIT);
  // fixed priority data > fetch > io, with io forced through once it has starved
  always_comb grant = (bus.ioReq && starved) ? IO : bus.dataReq ? DATA : bus.fetchReq ? FETCH : IO;
  // count ISSUE cycles that io loses; cleared when io wins or drops its request
  always_ff @(posedge clock) begin
    if (reset || !bus.ioReq || (issueNow && grant == IO)) starveCnt <= 4'd0;
    else if (issueNow && starveCnt != 4'hf) starveCnt <= starveCnt + 4'd1;
  end
`endif
  // state and owner registers; owner is captured at the grant
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ISSUE;
      owner <= FETCH;
    end else begin
      state <= stateNext;
      if (issueNow) owner <= grant;
    end
  end
  // next state and memory-side drive of the granted requester
  always_comb begin
    stateNext = state;
    memEn = 1'b0;
    memWe = 1'b0;
    memAddr = '0;
    memWData = '0;
    if (issueNow) begin
      stateNext = RESPOND;
      memEn = 1'b1;
      memWe = (grant == DATA) ? bus.dataWe : (grant == IO) && bus.ioWe;
      memAddr = (grant == DATA) ? bus.dataAddr : (grant == FETCH) ? bus.fetchAddr : bus.ioAddr;
      memWData = (grant == DATA) ? bus.dataWData : (grant == IO) ? bus.ioWData : '0;
    end else if (state == RESPOND) begin
      stateNext = ISSUE;
    end
  end
  assign fetchDone = respondNow && owner == FETCH;
  assign dataDone = respondNow && owner == DATA;
  assign ioDone = respondNow && owner == IO;
  // keep each owner's last response visible until its next one
  always_ff @(posedge clock) begin
    if (reset) begin
      fetchInstrHeld <= '0;
      dataRDataHeld <= '0;
      ioRDataHeld <= '0;
    end else begin
      if (fetchDone) fetchInstrHeld <= bus.memRData[INSTRUCTIONWIDTH-1:0];
      if (dataDone) dataRDataHeld <= bus.memRData;
      if (ioDone) ioRDataHeld <= bus.memRData;
    end
  end
  assign bus.memEn = memEn;
  assign bus.memWe = memWe;
  assign bus.memAddr = memAddr;
  assign bus.memWData = memWData;
  assign bus.fetchValid = fetchDone;
  assign bus.dataValid = dataDone;
  assign bus.ioValid = ioDone;
  assign bus.fetchInstr = fetchDone ? bus.memRData[INSTRUCTIONWIDTH-1:0] : fetchInstrHeld;
  assign bus.dataRData = dataDone ? bus.memRData : dataRDataHeld;
  assign bus.ioRData = ioDone ? bus.memRData : ioRDataHeld;
  assign bus.stallFetch = bus.fetchReq & ~fetchDone;
  assign bus.stallMem = bus.dataReq & ~dataDone;
  assign bus.busy = state == RESPOND;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant, response routing, stalls, starvation and reset
module tb_mem_port_arbiter;
  logic clock;
  logic reset;
  int total;
  int bad;
  logic [31:0] mem [256];
  mem_port_arbiter_if #(.WIDTH(32), .INSTRUCTIONWIDTH(24)) bus ();
  mem_port_arbiter #(.WIDTH(32), .INSTRUCTIONWIDTH(24), .STARVELIMIT(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  // synchronous memory: preloaded while reset is high, read data one cycle after memEn
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 5) ? 32'h00ABCDEF : 32'hA000 + 32'(i);
      bus.memRData <= 32'h0;
    end else if (bus.memEn) begin
      if (bus.memWe) mem[bus.memAddr[7:0]] <= bus.memWData;
      bus.memRData <= mem[bus.memAddr[7:0]];
    end
  end
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.fetchReq = 0; bus.fetchAddr = 0;
    bus.dataReq = 0; bus.dataWe = 0; bus.dataAddr = 0; bus.dataWData = 0;
    bus.ioReq = 0; bus.ioWe = 0; bus.ioAddr = 0; bus.ioWData = 0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_memEn", 32'(bus.memEn), 0);
    chk("rst_memWe", 32'(bus.memWe), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valids", {29'd0, bus.fetchValid, bus.dataValid, bus.ioValid}, 0);
    chk("rst_memAddr", bus.memAddr, 0);
    chk("rst_memWData", bus.memWData, 0);
    chk("rst_dataRData", bus.dataRData, 0);
    chk("rst_ioRData", bus.ioRData, 0);
    chk("rst_fetchInstr", 32'(bus.fetchInstr), 0);
    bus.fetchReq = 1; bus.fetchAddr = 5;
    #1;
    chk("f_memEn", 32'(bus.memEn), 1);
    chk("f_memAddr", bus.memAddr, 5);
    chk("f_memWe", 32'(bus.memWe), 0);
    chk("f_stall_t0", 32'(bus.stallFetch), 1);
    tick();
    chk("f_valid", 32'(bus.fetchValid), 1);
    chk("f_instr", 32'(bus.fetchInstr), 32'hABCDEF);
    chk("f_busy", 32'(bus.busy), 1);
    chk("f_memEn_resp", 32'(bus.memEn), 0);
    chk("f_stall_t1", 32'(bus.stallFetch), 0);
    bus.fetchReq = 0;
    tick();
    chk("f_valid_off", 32'(bus.fetchValid), 0);
    chk("f_instr_held", 32'(bus.fetchInstr), 32'hABCDEF);
    bus.dataReq = 1; bus.dataWe = 1; bus.dataAddr = 32'h10; bus.dataWData = 32'h1234;
    bus.fetchReq = 1; bus.fetchAddr = 5;
    #1;
    chk("st_memWe", 32'(bus.memWe), 1);
    chk("st_memAddr", bus.memAddr, 32'h10);
    chk("st_memWData", bus.memWData, 32'h1234);
    chk("st_stallFetch0", 32'(bus.stallFetch), 1);
    chk("st_stallMem0", 32'(bus.stallMem), 1);
    tick();
    chk("st_dataValid", 32'(bus.dataValid), 1);
    chk("st_stallMem1", 32'(bus.stallMem), 0);
    chk("st_stallFetch1", 32'(bus.stallFetch), 1);
    chk("st_memEn_resp", 32'(bus.memEn), 0);
    bus.dataReq = 0;
    tick();
    chk("st_f_memEn", 32'(bus.memEn), 1);
    chk("st_f_memAddr", bus.memAddr, 5);
    chk("st_f_memWe", 32'(bus.memWe), 0);
    chk("st_stallFetch2", 32'(bus.stallFetch), 1);
    tick();
    chk("st_f_valid", 32'(bus.fetchValid), 1);
    chk("st_stallFetch3", 32'(bus.stallFetch), 0);
    bus.fetchReq = 0;
    tick();
    bus.dataReq = 1; bus.dataWe = 0; bus.dataAddr = 32'h10;
    #1;
    chk("ld_memEn", 32'(bus.memEn), 1);
    chk("ld_memWe", 32'(bus.memWe), 0);
    chk("ld_memAddr", bus.memAddr, 32'h10);
    tick();
    chk("ld_valid", 32'(bus.dataValid), 1);
    chk("ld_rdata", bus.dataRData, 32'h1234);
    bus.dataReq = 0;
    tick();
    chk("ld_valid_off", 32'(bus.dataValid), 0);
    chk("ld_rdata_held", bus.dataRData, 32'h1234);
`ifdef ARB_ROUND_ROBIN_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.dataReq = 1; bus.dataWe = 0; bus.dataAddr = 32'h10;
    bus.fetchReq = 1; bus.fetchAddr = 5;
    bus.ioReq = 1; bus.ioWe = 0; bus.ioAddr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] order [3];
      order[0] = 32'h10; order[1] = 32'h5; order[2] = 32'h20;
      #1;
      chk("rr_memEn", 32'(bus.memEn), 1);
      chk("rr_memAddr", bus.memAddr, order[k % 3]);
      tick();
      chk("rr_gap", 32'(bus.memEn), 0);
      chk("rr_valids", {29'd0, bus.ioValid, bus.fetchValid, bus.dataValid}, 32'(1 << (k % 3)));
      tick();
    end
`else
    bus.dataReq = 1; bus.dataWe = 0; bus.dataAddr = 32'h10;
    bus.ioReq = 1; bus.ioWe = 1; bus.ioAddr = 32'h20; bus.ioWData = 32'h55;
    for (int k = 1; k <= 18; k++) begin
      logic ioTurn;
      ioTurn = (k % 9) == 0;
      #1;
      chk("sv_memAddr", bus.memAddr, ioTurn ? 32'h20 : 32'h10);
      chk("sv_memWe", 32'(bus.memWe), 32'(ioTurn));
      tick();
      chk("sv_ioValid", 32'(bus.ioValid), 32'(ioTurn));
      chk("sv_dataValid", 32'(bus.dataValid), 32'(!ioTurn));
      if (k == 9) chk("sv_ioRData_first", bus.ioRData, 32'hA020);
      if (k == 18) chk("sv_ioRData_second", bus.ioRData, 32'h55);
      tick();
    end
`endif
    bus.dataReq = 0; bus.ioReq = 0; bus.fetchReq = 0;
    tick();
    bus.fetchReq = 1; bus.fetchAddr = 7;
    #1;
    chk("rr_f_memEn", 32'(bus.memEn), 1);
    chk("rr_f_memAddr", bus.memAddr, 7);
    tick();
    reset = 1'b1;
    #1;
    chk("rs_no_valid", 32'(bus.fetchValid), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rs_busy", 32'(bus.busy), 0);
    chk("rs_reissue_memEn", 32'(bus.memEn), 1);
    chk("rs_reissue_addr", bus.memAddr, 7);
    tick();
    chk("rs_valid", 32'(bus.fetchValid), 1);
    chk("rs_instr", 32'(bus.fetchInstr), 32'h00A007);
    bus.fetchReq = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
